// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Sequencing, forwarding, trap and memory-stall control for the
//            3-stage IF | DE | MW pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic [4:0]       rd_mw,
  input  logic             reg_wr_mw,
  input  logic             mem_rd_mw,
  input  logic             mem_wr_mw,
  input  logic             dmem_ack,
  input  logic             br_taken_de,
  input  logic             mret_de,
  input  logic             intr_req,
  output logic [1:0]       pc_sel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             demw_en,
  output logic             demw_flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             dmem_req,
  output logic             intr_ack,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0]       ST_RUN      = 1'b0;
  localparam logic [0:0]       ST_MEM_WAIT = 1'b1;
  localparam logic [1:0]       C_PC_SEQ    = 2'b00;
  localparam logic [1:0]       C_PC_BR     = 2'b01;
  localparam logic [1:0]       C_PC_MTVEC  = 2'b10;
  localparam logic [1:0]       C_PC_EPC    = 2'b11;
  localparam logic [7:0]       C_TIMEOUT   = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  logic [0:0]       fsm_q, fsm_d;
  logic             in_trap_q, in_trap_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             w_mem_op;
  logic             w_redirect;

  assign w_mem_op  = mem_rd_mw | mem_wr_mw;
  assign fwd_a     = reg_wr_mw & (rd_mw != 5'd0) & (rd_mw == rs1_de);
  assign fwd_b     = reg_wr_mw & (rd_mw != 5'd0) & (rd_mw == rs2_de);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    pc_sel      = C_PC_SEQ;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    demw_en     = 1'b1;
    demw_flush  = 1'b0;
    dmem_req    = w_mem_op;
    intr_ack    = 1'b0;
    bus_err     = 1'b0;
    w_redirect  = 1'b0;
    fsm_d       = fsm_q;
    in_trap_d   = in_trap_q;
    wait_cnt_d  = wait_cnt_q;

    case (fsm_q)
      ST_RUN: begin
        if (w_mem_op && !dmem_ack) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          demw_en    = 1'b0;
          fsm_d      = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          w_redirect = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          fsm_d      = ST_RUN;
          wait_cnt_d = 8'd0;
          w_redirect = 1'b1;
        end else if (wait_cnt_q == C_TIMEOUT) begin
          // Abandoned access is reported as a trap through mtvec.
          bus_err    = 1'b1;
          dmem_req   = 1'b0;
          pc_sel     = C_PC_MTVEC;
          ifid_flush = 1'b1;
          demw_flush = 1'b1;
          in_trap_d  = 1'b1;
          fsm_d      = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          demw_en    = 1'b0;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: fsm_d = ST_RUN;
    endcase

    if (w_redirect) begin
      if (intr_req && !in_trap_q) begin
        pc_sel     = C_PC_MTVEC;
        ifid_flush = 1'b1;
        demw_flush = 1'b1;
        intr_ack   = 1'b1;
        in_trap_d  = 1'b1;
      end else if (mret_de) begin
        pc_sel     = C_PC_EPC;
        ifid_flush = 1'b1;
        in_trap_d  = 1'b0;
      end else if (br_taken_de) begin
        pc_sel     = C_PC_BR;
        ifid_flush = 1'b1;
      end
    end

    stall_cnt_d = (!pc_en && (stall_cnt_q != C_CNT_MAX)) ? stall_cnt_q + 1'b1
                                                          : stall_cnt_q;

    if (!rst) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      demw_flush = 1'b1;
      dmem_req   = 1'b0;
      intr_ack   = 1'b0;
      bus_err    = 1'b0;
      pc_sel     = C_PC_SEQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q       <= ST_RUN;
      in_trap_q   <= 1'b0;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      in_trap_q   <= in_trap_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed vector table plus hand sequences for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_de, rs2_de, rd_mw;
  logic       reg_wr_mw, mem_rd_mw, mem_wr_mw, dmem_ack;
  logic       br_taken_de, mret_de, intr_req;
  logic [1:0] pc_sel;
  logic       pc_en, ifid_en, ifid_flush, demw_en, demw_flush;
  logic       fwd_a, fwd_b, dmem_req, intr_ack, bus_err;
  logic [3:0] stall_cnt;
  logic [9:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // ctl: {reg_wr, mem_rd, mem_wr, ack, br, mret, intr}
  // ex : {pc_en, ifid_en, ifid_flush, demw_en, demw_flush, fwd_a, fwd_b, dmem_req, intr_ack, bus_err}
  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [6:0] ctl;
    logic [1:0] pcs;
    logic [9:0] ex;
  } vec_t;

  vec_t vecs[15];

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_mw(rd_mw),
    .reg_wr_mw(reg_wr_mw), .mem_rd_mw(mem_rd_mw), .mem_wr_mw(mem_wr_mw),
    .dmem_ack(dmem_ack), .br_taken_de(br_taken_de), .mret_de(mret_de),
    .intr_req(intr_req), .pc_sel(pc_sel), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .demw_en(demw_en), .demw_flush(demw_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req),
    .intr_ack(intr_ack), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {pc_en, ifid_en, ifid_flush, demw_en, demw_flush,
                fwd_a, fwd_b, dmem_req, intr_ack, bus_err};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [6:0] ctl);
    rs1_de = rs1; rs2_de = rs2; rd_mw = rd;
    {reg_wr_mw, mem_rd_mw, mem_wr_mw, dmem_ack, br_taken_de, mret_de, intr_req} = ctl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string nm, input logic [6:0] ctl,
                          input logic [1:0] pcs, input logic [9:0] ex);
    drive(5'd0, 5'd0, 5'd0, ctl);
    #1;
    chk({nm, ".pc_sel"}, 32'(pc_sel), 32'(pcs));
    chk({nm, ".ctrl"}, 32'(obs), 32'(ex));
    tick();
  endtask

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 7'b0000000, 2'b00, 10'b1101000000};
    vecs[1]  = '{5'd5, 5'd5, 5'd5, 7'b1000000, 2'b00, 10'b1101011000};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 7'b1000000, 2'b00, 10'b1101000000};
    vecs[3]  = '{5'd5, 5'd6, 5'd5, 7'b1000000, 2'b00, 10'b1101010000};
    vecs[4]  = '{5'd3, 5'd7, 5'd7, 7'b0000000, 2'b00, 10'b1101000000};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 7'b0000100, 2'b01, 10'b1111000000};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 7'b0101000, 2'b00, 10'b1101000100};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 7'b0011100, 2'b01, 10'b1111000100};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 7'b0000010, 2'b11, 10'b1111000000};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 7'b0000101, 2'b10, 10'b1111100010};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 7'b0000001, 2'b00, 10'b1101000000};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 7'b0000101, 2'b01, 10'b1111000000};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 7'b0000011, 2'b11, 10'b1111000000};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 7'b0000001, 2'b10, 10'b1111100010};
    vecs[14] = '{5'd0, 5'd0, 5'd0, 7'b0000010, 2'b11, 10'b1111000000};

    // Reset held for two edges with a memory op and interrupt pending.
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 7'b0100001);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst.dmem_req", 32'(dmem_req), 32'd0);
      chk("rst.pc_en", 32'(pc_en), 32'd0);
      chk("rst.flush", 32'({ifid_flush, demw_flush}), 32'd3);
      chk("rst.pulses", 32'({intr_ack, bus_err, pc_sel}), 32'd0);
    end
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 7'b0000000);
    #1;
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst.release", 32'(obs), 32'(10'b1101000000));
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].ctl);
      #1;
      chk($sformatf("vec%0d.pc_sel", i), 32'(pc_sel), 32'(vecs[i].pcs));
      chk($sformatf("vec%0d.ctrl", i), 32'(obs), 32'(vecs[i].ex));
      tick();
    end
    #1;
    chk("table.stall_cnt", 32'(stall_cnt), 32'd0);

    // Load acked in cycle 4; redirects ignored while waiting, branch honoured on ack.
    step_chk("ld1.c1", 7'b0100000, 2'b00, 10'b0000000100);
    step_chk("ld1.c2", 7'b0100101, 2'b00, 10'b0000000100);
    step_chk("ld1.c3", 7'b0100000, 2'b00, 10'b0000000100);
    step_chk("ld1.c4", 7'b0101100, 2'b01, 10'b1111000100);
    drive(5'd0, 5'd0, 5'd0, 7'b0000000);
    #1;
    chk("ld1.stall_cnt", 32'(stall_cnt), 32'd3);

    // Interrupt deferred through the stall, taken on the ack cycle.
    step_chk("ld2.c1", 7'b0100001, 2'b00, 10'b0000000100);
    step_chk("ld2.c2", 7'b0101001, 2'b10, 10'b1111100110);
    step_chk("ld2.mret", 7'b0000010, 2'b11, 10'b1111000000);

    // Timeout: bus_err in cycle TIMEOUT+1, then interrupts blocked by in_trap.
    for (int c = 1; c <= 4; c++)
      step_chk($sformatf("to.c%0d", c), 7'b0100000, 2'b00, 10'b0000000100);
    step_chk("to.c5", 7'b0100000, 2'b10, 10'b1111100001);
    drive(5'd0, 5'd0, 5'd0, 7'b0000000);
    #1;
    chk("to.stall_cnt", 32'(stall_cnt), 32'd8);
    step_chk("to.intr_blocked", 7'b0000001, 2'b00, 10'b1101000000);
    step_chk("to.mret", 7'b0000010, 2'b11, 10'b1111000000);

    // Reset in the middle of a wait drops the access.
    step_chk("rmw.c1", 7'b0100000, 2'b00, 10'b0000000100);
    step_chk("rmw.c2", 7'b0100000, 2'b00, 10'b0000000100);
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 7'b0100000);
    #1;
    chk("rmw.dmem_req", 32'(dmem_req), 32'd0);
    chk("rmw.pc_en", 32'(pc_en), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rmw.stall_cnt", 32'(stall_cnt), 32'd0);
    step_chk("rmw.run", 7'b0000100, 2'b01, 10'b1111000000);

    // Back-to-back timeouts: 4 stall cycles per 5; 25 cycles give 20 stalls.
    drive(5'd0, 5'd0, 5'd0, 7'b0100000);
    for (int c = 0; c < 10; c++) tick();
    chk("sat.mid", 32'(stall_cnt), 32'd8);
    for (int c = 0; c < 15; c++) tick();
    chk("sat.hold", 32'(stall_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
